// File: rtl/seg7_updown_counter.sv
// Up/down counter with enable-gated prescaler, clamped synchronous load, wrap strobe,
// wrap-toggled decimal point and a hex seven-segment decode of the low digit.
module seg7_updown_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 9,
    parameter int unsigned PRESCALE  = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [6:0]       seg,
    output logic             dp,
    output logic             wrap
);

    localparam int unsigned      PreW    = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);
    localparam logic [PreW-1:0]  PreLast = PreW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX_COUNT);

    logic [PreW-1:0]  pre_q, pre_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             dp_q, dp_d;
    logic             step;

    assign step = enable && (pre_q == PreLast);

    always_comb begin
        pre_d   = pre_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        dp_d    = dp_q;
        if (load) begin
            // Load overrides a coincident step and restarts the prescaler phase.
            pre_d   = '0;
            count_d = (load_val > MaxVal) ? MaxVal : load_val;
        end else if (step) begin
            pre_d = '0;
            if (up_down) begin
                if (count_q == MaxVal) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                    dp_d    = ~dp_q;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MaxVal;
                    wrap_d  = 1'b1;
                    dp_d    = ~dp_q;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end else if (enable) begin
            pre_d = pre_q + PreW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            dp_q    <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            dp_q    <= dp_d;
        end
    end

    always_comb begin
        seg = 7'h00;
        unique case (count_q[3:0])
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign dp    = dp_q;

endmodule

// File: tb/tb_seg7_updown_counter.sv
// Three counter configurations driven by directed sequences, checked every cycle against a
// behavioural model plus hand-computed literal expectations.
module tb_seg7_updown_counter;

    localparam int MaxC [3] = '{9, 9, 200};
    localparam int Pres [3] = '{4, 1, 4};
    localparam int Wid  [3] = '{4, 4, 8};
    localparam logic [6:0] SegTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
        7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic       clk = 1'b0;
    logic       rst [3];
    logic       en  [3];
    logic       ud  [3];
    logic       ld  [3];
    logic [7:0] lv  [3];
    logic [3:0] cnt0, cnt1;
    logic [7:0] cnt2;
    logic [6:0] seg_o  [3];
    logic       dp_o   [3];
    logic       wrap_o [3];

    int n_vec = 0;
    int n_err = 0;

    int m_ph [3];
    int m_cnt [3];
    int m_dp [3];
    int m_wrap [3];

    always #5 clk = ~clk;

    seg7_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(4)) u_a (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .up_down(ud[0]), .load(ld[0]),
        .load_val(lv[0][3:0]), .count(cnt0), .seg(seg_o[0]), .dp(dp_o[0]), .wrap(wrap_o[0])
    );
    seg7_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1)) u_b (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .up_down(ud[1]), .load(ld[1]),
        .load_val(lv[1][3:0]), .count(cnt1), .seg(seg_o[1]), .dp(dp_o[1]), .wrap(wrap_o[1])
    );
    seg7_updown_counter #(.WIDTH(8), .MAX_COUNT(200), .PRESCALE(4)) u_c (
        .clk(clk), .reset(rst[2]), .enable(en[2]), .up_down(ud[2]), .load(ld[2]),
        .load_val(lv[2]), .count(cnt2), .seg(seg_o[2]), .dp(dp_o[2]), .wrap(wrap_o[2])
    );

    function automatic int act_cnt(int i);
        return (i == 0) ? int'(cnt0) : (i == 1) ? int'(cnt1) : int'(cnt2);
    endfunction

    task automatic chk(string name, int idx, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, idx, $time, act, act, exp, exp);
        end
    endtask

    // Model: count moves modulo MAX+1, a step every PRESCALE enabled cycles.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                m_ph[i] <= 0; m_cnt[i] <= 0; m_dp[i] <= 0; m_wrap[i] <= 0;
            end else if (ld[i]) begin
                int v;
                v = int'(lv[i]) % (1 << Wid[i]);
                m_cnt[i]  <= (v > MaxC[i]) ? MaxC[i] : v;
                m_ph[i]   <= 0;
                m_wrap[i] <= 0;
            end else if (en[i] && m_ph[i] == Pres[i] - 1) begin
                int wr;
                wr = ud[i] ? int'(m_cnt[i] == MaxC[i]) : int'(m_cnt[i] == 0);
                m_ph[i]   <= 0;
                m_cnt[i]  <= ud[i] ? (m_cnt[i] + 1) % (MaxC[i] + 1)
                                   : (m_cnt[i] + MaxC[i]) % (MaxC[i] + 1);
                m_wrap[i] <= wr;
                m_dp[i]   <= m_dp[i] ^ wr;
            end else begin
                m_wrap[i] <= 0;
                if (en[i]) m_ph[i] <= m_ph[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int ec;
            ec = rst[i] ? 0 : m_cnt[i];
            chk("model_count", i, act_cnt(i), ec);
            chk("model_seg", i, int'(seg_o[i]), int'(SegTab[ec % 16]));
            chk("model_dp", i, int'(dp_o[i]), rst[i] ? 0 : m_dp[i]);
            chk("model_wrap", i, int'(wrap_o[i]), rst[i] ? 0 : m_wrap[i]);
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(int i, int c, int s, int d, int w);
        chk("lit_count", i, act_cnt(i), c);
        chk("lit_seg", i, int'(seg_o[i]), s);
        chk("lit_dp", i, int'(dp_o[i]), d);
        chk("lit_wrap", i, int'(wrap_o[i]), w);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; ud[i] = 1'b1; ld[i] = 1'b0; lv[i] = 8'd0;
            m_ph[i] = 0; m_cnt[i] = 0; m_dp[i] = 0; m_wrap[i] = 0;
        end
        tick(2);

        // Instance A: reset release with enable, first steps at edges 4 and 8.
        rst[0] = 1'b0; en[0] = 1'b1;
        #1 lit(0, 0, 'h3F, 0, 0);
        tick(3); lit(0, 0, 'h3F, 0, 0);
        tick(1); lit(0, 1, 'h06, 0, 0);
        tick(4); lit(0, 2, 'h5B, 0, 0);
        en[0] = 1'b0;

        // Enable gating freezes the prescaler phase.
        en[0] = 1'b1; tick(2); en[0] = 1'b0;
        tick(10); lit(0, 2, 'h5B, 0, 0);
        en[0] = 1'b1;
        tick(1); lit(0, 2, 'h5B, 0, 0);
        tick(1); lit(0, 3, 'h4F, 0, 0);
        en[0] = 1'b0;

        // Load on a step cycle: clamp, priority, prescaler restart.
        en[0] = 1'b1; tick(3);
        ld[0] = 1'b1; lv[0] = 8'd12;
        tick(1); lit(0, 9, 'h6F, 0, 0);
        lv[0] = 8'd5;
        tick(1); lit(0, 5, 'h6D, 0, 0);
        ld[0] = 1'b0;
        tick(3); lit(0, 5, 'h6D, 0, 0);
        tick(1); lit(0, 6, 'h7D, 0, 0);
        en[0] = 1'b0;

        // Down wrap from 0.
        ld[0] = 1'b1; lv[0] = 8'd0; tick(1);
        ld[0] = 1'b0; ud[0] = 1'b0; en[0] = 1'b1;
        tick(3); lit(0, 0, 'h3F, 0, 0);
        tick(1); lit(0, 9, 'h6F, 1, 1);
        tick(1); lit(0, 9, 'h6F, 1, 0);
        tick(3); lit(0, 8, 'h7F, 1, 0);
        en[0] = 1'b0;

        // Instance B (PRESCALE=1): up wraps, then back-to-back wrap via direction change.
        rst[1] = 1'b0; en[1] = 1'b1;
        tick(9);  lit(1, 9, 'h6F, 0, 0);
        tick(1);  lit(1, 0, 'h3F, 1, 1);
        tick(1);  lit(1, 1, 'h06, 1, 0);
        tick(9);  lit(1, 0, 'h3F, 0, 1);
        ud[1] = 1'b0;
        tick(1);  lit(1, 9, 'h6F, 1, 1);
        tick(1);  lit(1, 8, 'h7F, 1, 0);
        en[1] = 1'b0;

        // Instance C: count to 150, reset between edges, resume from 0.
        rst[2] = 1'b0; en[2] = 1'b1;
        tick(600); lit(2, 150, 'h7D, 0, 0);
        rst[2] = 1'b1;
        #1 lit(2, 0, 'h3F, 0, 0);
        tick(1);
        rst[2] = 1'b0;
        tick(3); lit(2, 0, 'h3F, 0, 0);
        tick(1); lit(2, 1, 'h06, 0, 0);

        // Instance C loads: in-range value and clamp to 200, then up wrap.
        ld[2] = 1'b1; lv[2] = 8'd12;
        tick(1); lit(2, 12, 'h39, 0, 0);
        lv[2] = 8'd250;
        tick(1); lit(2, 200, 'h7F, 0, 0);
        ld[2] = 1'b0;
        tick(3); lit(2, 200, 'h7F, 0, 0);
        tick(1); lit(2, 0, 'h3F, 1, 1);
        tick(1); lit(2, 0, 'h3F, 1, 0);
        en[2] = 1'b0;

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
